// File: rtl/mysystem_length_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mysystem_length_sequencer
// Purpose  : Turns a software-programmed 7-bit transfer length into a stream
//            of sequential words (BASE, BASE+1, ...) on a valid/ready source.
//            A run starts on a 0->1 transition of start, flags the final word
//            with src_last and pulses done after the final handshake.
// Ports    : clk, reset (sync, active-high)
//            length[6:0]  word count, sampled only on a start edge
//            start        level; a rising edge begins a run
//            abort        ends a run without done
//            src_data/src_valid/src_ready/src_last  word stream
//            busy, done (1-cycle pulse), sent_count[7:0]
// Options  : LENSEQ_ZERO_IS_128_EN - when defined, length 0 means 128 words;
//            otherwise length 0 completes at once with a done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module mysystem_length_sequencer #(
   parameter int                DATA_W = 16,
   parameter logic [DATA_W-1:0] BASE   = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [6:0]        length,
   input  logic              start,
   input  logic              abort,
   output logic [DATA_W-1:0] src_data,
   output logic              src_valid,
   input  logic              src_ready,
   output logic              src_last,
   output logic              busy,
   output logic              done,
   output logic [7:0]        sent_count
);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   state_t            state_q, state_d;
   logic              start_q;
   logic [7:0]        len_q, len_d;
   logic [7:0]        index_q, index_d;
   logic [7:0]        sent_q, sent_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              last_q, last_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              start_edge;
   logic              handshake;
   logic              zero_run;
   logic [7:0]        len_eff;
   logic [7:0]        next_index;

   assign start_edge = start & ~start_q;
   assign handshake  = valid_q & src_ready;
   assign next_index = index_q + 8'd1;

`ifdef LENSEQ_ZERO_IS_128_EN
   // A zero length wraps to the full 7-bit range plus one.
   assign len_eff  = (length == 7'd0) ? 8'd128 : {1'b0, length};
   assign zero_run = 1'b0;
`else
   assign len_eff  = {1'b0, length};
   assign zero_run = (length == 7'd0);
`endif

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      index_d = index_q;
      sent_d  = sent_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            // abort outranks a coincident start edge.
            if (start_edge && !abort) begin
               sent_d = 8'd0;
               if (zero_run) begin
                  done_d = 1'b1;
               end else begin
                  state_d = S_RUN;
                  len_d   = len_eff;
                  index_d = 8'd0;
                  data_d  = BASE;
                  valid_d = 1'b1;
                  busy_d  = 1'b1;
                  last_d  = (len_eff == 8'd1);
               end
            end
         end

         S_RUN: begin
            // A word the sink took is counted even if abort arrives with it.
            if (handshake) begin
               sent_d  = sent_q + 8'd1;
               index_d = next_index;
            end
            if (abort) begin
               state_d = S_IDLE;
               valid_d = 1'b0;
               busy_d  = 1'b0;
               last_d  = 1'b0;
            end else if (handshake) begin
               if (last_q) begin
                  state_d = S_IDLE;
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  last_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  // Next word is prepared a cycle ahead so all outputs stay registered.
                  data_d = BASE + DATA_W'(next_index);
                  last_d = (next_index == (len_q - 8'd1));
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         start_q <= 1'b1;   // start held high through reset must drop before it counts
         len_q   <= 8'd0;
         index_q <= 8'd0;
         sent_q  <= 8'd0;
         data_q  <= BASE;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start;
         len_q   <= len_d;
         index_q <= index_d;
         sent_q  <= sent_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign src_data   = data_q;
   assign src_valid  = valid_q;
   assign src_last   = last_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign sent_count = sent_q;

endmodule
`default_nettype wire

// File: tb/tb_mysystem_length_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mysystem_length_sequencer
// Purpose  : Self-checking bench for mysystem_length_sequencer. Each run's
//            expected stream is derived from the length alone (word k is
//            BASE+k, last at k = L-1, done after L accepted words).
//            Honours LENSEQ_ZERO_IS_128_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mysystem_length_sequencer;

   localparam int          DATA_W = 16;
   localparam logic [15:0] BASE   = 16'hFFFC;   // close to the top so runs wrap
`ifdef LENSEQ_ZERO_IS_128_EN
   localparam bit ZERO_IS_128 = 1'b1;
`else
   localparam bit ZERO_IS_128 = 1'b0;
`endif

   logic              clk;
   logic              reset;
   logic [6:0]        length;
   logic              start;
   logic              abort;
   logic [DATA_W-1:0] src_data;
   logic              src_valid;
   logic              src_ready;
   logic              src_last;
   logic              busy;
   logic              done;
   logic [7:0]        sent_count;

   int n_checks;
   int n_fail;

   mysystem_length_sequencer #(.DATA_W(DATA_W), .BASE(BASE)) dut (
      .clk        (clk),
      .reset      (reset),
      .length     (length),
      .start      (start),
      .abort      (abort),
      .src_data   (src_data),
      .src_valid  (src_valid),
      .src_ready  (src_ready),
      .src_last   (src_last),
      .busy       (busy),
      .done       (done),
      .sent_count (sent_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] word(input int k);
      return BASE + 16'(k);
   endfunction

   // Drives one run and checks it against the length-derived expectation.
   // mode 0: ready always high, 1: ready pattern 1,0,0,1,0,1, 2: random ready.
   // poke: make a second start edge and change length during the run.
   task automatic drive_run(input int len_in, input int mode, input bit poke);
      int          eff;
      int          k;
      int          cyc;
      bit          rdy;
      bit          pat [6];
      logic [19:0] act, exp;
      logic [10:0] act_s, exp_s;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      eff = (len_in == 0) ? (ZERO_IS_128 ? 128 : 0) : len_in;
      start = 1'b0; src_ready = 1'b0; tick();
      length = 7'(len_in); start = 1'b1; tick();
      if (eff == 0) begin
         act_s = {src_valid, busy, done, sent_count};
         exp_s = {1'b0, 1'b0, 1'b1, 8'd0};
         n_checks++;
         if (act_s !== exp_s) begin
            n_fail++;
            $display("FAIL zero_len {valid,busy,done,sent} got %h expected %h", act_s, exp_s);
         end
         tick();
         n_checks++;
         if (done !== 1'b0 || src_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len_after done=%b valid=%b expected 0 0", done, src_valid);
         end
         start = 1'b0;
         return;
      end
      k = 0; cyc = 0;
      while (k < eff && cyc < 4000) begin
         act = {src_valid, busy, src_last, done, src_data};
         exp = {1'b1, 1'b1, (k == eff - 1), 1'b0, word(k)};
         n_checks++;
         if (act !== exp) begin
            n_fail++;
            $display("FAIL word%0d len=%0d {valid,busy,last,done,data} got %h expected %h",
                     k, len_in, act, exp);
         end
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = pat[cyc % 6];
            default: rdy = ($urandom_range(0, 2) != 0);
         endcase
         if (poke) begin
            if (cyc == 0) start = 1'b0;
            if (cyc == 1) begin start = 1'b1; length = 7'd9; end
         end
         src_ready = rdy;
         tick();
         if (rdy) k++;
         cyc++;
      end
      n_checks++;
      if (k < eff) begin
         n_fail++;
         $display("FAIL run_timeout len=%0d accepted %0d expected %0d", len_in, k, eff);
      end
      act_s = {src_valid, busy, done, sent_count};
      exp_s = {1'b0, 1'b0, 1'b1, 8'(eff)};
      n_checks++;
      if (act_s !== exp_s || src_last !== 1'b0) begin
         n_fail++;
         $display("FAIL run_end len=%0d {valid,busy,done,sent} got %h last=%b expected %h last=0",
                  len_in, act_s, src_last, exp_s);
      end
      src_ready = 1'b0;
      tick();
      n_checks++;
      if ({src_valid, busy, done} !== 3'b000) begin
         n_fail++;
         $display("FAIL run_idle len=%0d {valid,busy,done} got %b expected 000",
                  len_in, {src_valid, busy, done});
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      logic [27:0] act;
      reset = 1'b1; start = 1'b0; abort = 1'b0; src_ready = 1'b0; length = 7'd0;
      tick(); tick();
      act = {src_valid, src_last, busy, done, sent_count, src_data};
      n_checks++;
      if (act !== {4'b0000, 8'd0, BASE}) begin
         n_fail++;
         $display("FAIL reset_values got %h expected %h", act, {4'b0000, 8'd0, BASE});
      end
      reset = 1'b0; tick();
      act = {src_valid, src_last, busy, done, sent_count, src_data};
      n_checks++;
      if (act !== {4'b0000, 8'd0, BASE}) begin
         n_fail++;
         $display("FAIL post_reset got %h expected %h", act, {4'b0000, 8'd0, BASE});
      end
   endtask

   task automatic test_basic();
      drive_run(5, 0, 1'b0);
      drive_run(1, 0, 1'b0);
   endtask

   task automatic test_stall();
      drive_run(3, 1, 1'b0);
   endtask

   task automatic test_mid_run_start();
      drive_run(4, 0, 1'b1);
   endtask

   task automatic test_zero_length();
      drive_run(0, 0, 1'b0);
   endtask

   task automatic test_abort();
      start = 1'b0; tick();
      length = 7'd10; start = 1'b1; src_ready = 1'b1; tick();
      tick(); tick();                         // words 0 and 1 accepted
      n_checks++;
      if (src_data !== word(2) || sent_count !== 8'd2) begin
         n_fail++;
         $display("FAIL abort_pre data=%h sent=%0d expected %h 2", src_data, sent_count, word(2));
      end
      abort = 1'b1; src_ready = 1'b0; tick();
      n_checks++;
      if ({src_valid, busy, done, sent_count} !== {3'b000, 8'd2}) begin
         n_fail++;
         $display("FAIL abort_run {valid,busy,done,sent} got %h expected %h",
                  {src_valid, busy, done, sent_count}, {3'b000, 8'd2});
      end
      abort = 1'b0; tick();
      n_checks++;
      if (done !== 1'b0 || sent_count !== 8'd2) begin
         n_fail++;
         $display("FAIL abort_after done=%b sent=%0d expected 0 2", done, sent_count);
      end
      start = 1'b0; tick();
      start = 1'b1; abort = 1'b1; length = 7'd3; tick();
      abort = 1'b0; tick();
      n_checks++;
      if ({src_valid, busy, done, sent_count} !== {3'b000, 8'd2}) begin
         n_fail++;
         $display("FAIL abort_beats_start {valid,busy,done,sent} got %h expected %h",
                  {src_valid, busy, done, sent_count}, {3'b000, 8'd2});
      end
      start = 1'b0;
   endtask

   task automatic test_back_to_back();
      start = 1'b0; src_ready = 1'b1; tick();
      length = 7'd2; start = 1'b1; tick();
      start = 1'b0; tick();
      n_checks++;
      if (src_data !== word(1) || src_last !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_last data=%h last=%b expected %h 1", src_data, src_last, word(1));
      end
      start = 1'b1; tick();                   // edge together with final handshake
      n_checks++;
      if ({src_valid, busy, done} !== 3'b001) begin
         n_fail++;
         $display("FAIL b2b_done {valid,busy,done} got %b expected 001", {src_valid, busy, done});
      end
      start = 1'b0; length = 7'd3; tick();
      n_checks++;
      if ({src_valid, busy, done} !== 3'b000) begin
         n_fail++;
         $display("FAIL b2b_edge_ignored {valid,busy,done} got %b expected 000",
                  {src_valid, busy, done});
      end
      start = 1'b1; tick();
      start = 1'b0; tick(); tick();
      tick();                                 // final handshake of the 3-word run
      n_checks++;
      if ({busy, done, sent_count} !== {2'b01, 8'd3}) begin
         n_fail++;
         $display("FAIL b2b_done2 {busy,done,sent} got %h expected %h",
                  {busy, done, sent_count}, {2'b01, 8'd3});
      end
      start = 1'b1; tick();                   // edge in the done cycle is accepted
      n_checks++;
      if ({src_valid, busy, done, sent_count, src_data} !== {3'b110, 8'd0, BASE}) begin
         n_fail++;
         $display("FAIL b2b_restart got %h expected %h",
                  {src_valid, busy, done, sent_count, src_data}, {3'b110, 8'd0, BASE});
      end
      abort = 1'b1; src_ready = 1'b0; tick();
      abort = 1'b0; start = 1'b0; tick();
   endtask

   task automatic test_start_held();
      logic [27:0] act;
      reset = 1'b1; start = 1'b1; length = 7'd2; tick(); tick();
      reset = 1'b0; tick(); tick(); tick();
      n_checks++;
      if ({src_valid, busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL held_start {valid,busy} got %b expected 00", {src_valid, busy});
      end
      start = 1'b0; tick();
      start = 1'b1; tick();
      n_checks++;
      if ({src_valid, busy, src_data} !== {2'b11, BASE}) begin
         n_fail++;
         $display("FAIL held_restart got %h expected %h", {src_valid, busy, src_data}, {2'b11, BASE});
      end
      src_ready = 1'b1; tick();
      reset = 1'b1; src_ready = 1'b0; tick();
      act = {src_valid, src_last, busy, done, sent_count, src_data};
      n_checks++;
      if (act !== {4'b0000, 8'd0, BASE}) begin
         n_fail++;
         $display("FAIL reset_mid_run got %h expected %h", act, {4'b0000, 8'd0, BASE});
      end
      reset = 1'b0; tick();
      n_checks++;
      if ({src_valid, busy, done} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_no_done {valid,busy,done} got %b expected 000", {src_valid, busy, done});
      end
      start = 1'b0; tick();
   endtask

   task automatic test_random_runs();
      int len;
      drive_run(127, 2, 1'b0);
      for (int i = 0; i < 10; i++) begin
         len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 24));
         drive_run(len, 2, 1'b0);
      end
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      reset     = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      src_ready = 1'b0;
      length    = 7'd0;
      test_reset();
      test_basic();
      test_stall();
      test_mid_run_start();
      test_abort();
      test_zero_length();
      test_back_to_back();
      test_start_held();
      test_random_runs();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
